// File: rtl/cell_link_packet_arbiter_if.sv
// AXI-Stream link bundle shared by the two inputs and the outbound cell link.
interface cell_link_packet_arbiter_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  tvalid;
  logic                  tready;
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tlast;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/cell_link_packet_arbiter.sv
// Packet-granular round-robin arbiter: two AXI-Stream inputs onto one registered
// cell-link output, with over-length truncation/flush and saturating statistics.
//
// state  | meaning
// IDLE   | no grant; arbitrate between qualified requests (no transfer this cycle)
// GRANT0 | input 0 owns the link until TLAST or truncation
// GRANT1 | input 1 owns the link until TLAST or truncation
// FLUSH0 | input 0 truncated; drain its remaining beats until TLAST
// FLUSH1 | input 1 truncated; drain its remaining beats until TLAST
module cell_link_packet_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int MAX_PKT_WORDS = 16,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                         ACLK,
  input  logic                         ARESETN,
  cell_link_packet_arbiter_if.slave    s00_axis,
  cell_link_packet_arbiter_if.slave    s01_axis,
  cell_link_packet_arbiter_if.master   m00_axis,
  input  logic                         S00_ARB_REQ_SUPPRESS,
  input  logic                         S01_ARB_REQ_SUPPRESS,
  output logic [CNT_WIDTH-1:0]         PKT_COUNT_00,
  output logic [CNT_WIDTH-1:0]         PKT_COUNT_01,
  output logic [CNT_WIDTH-1:0]         TRUNC_COUNT,
  output logic [1:0]                   ACTIVE_GRANT
);

  localparam int WC_W = $clog2(MAX_PKT_WORDS);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    GRANT0 = 3'd1,
    GRANT1 = 3'd2,
    FLUSH0 = 3'd3,
    FLUSH1 = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic [WC_W-1:0]       wcnt_q, wcnt_d;
  logic                  m_valid_q, m_valid_d;
  logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic                  m_last_q, m_last_d;
  logic [CNT_WIDTH-1:0]  pkt0_q, pkt1_q, trunc_q;
  logic [1:0]            active_grant_q;

  logic                  pkt0_inc, pkt1_inc, trunc_inc;
  logic                  s0_ready, s1_ready;
  logic                  req0, req1, load, gnt1, at_max;
  logic                  sel_valid, sel_last;
  logic [DATA_WIDTH-1:0] sel_data;

  assign req0   = s00_axis.tvalid & ~S00_ARB_REQ_SUPPRESS;
  assign req1   = s01_axis.tvalid & ~S01_ARB_REQ_SUPPRESS;
  // The output register may take a new beat when empty or being drained this cycle.
  assign load   = ~m_valid_q | m00_axis.tready;
  assign gnt1   = (state_q == GRANT1);
  assign at_max = (wcnt_q == WC_W'(MAX_PKT_WORDS - 1));

  assign sel_valid = gnt1 ? s01_axis.tvalid : s00_axis.tvalid;
  assign sel_data  = gnt1 ? s01_axis.tdata  : s00_axis.tdata;
  assign sel_last  = gnt1 ? s01_axis.tlast  : s00_axis.tlast;

  // Next-state, handshake and output-register load decisions.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    wcnt_d       = wcnt_q;
    m_valid_d    = m_valid_q;
    m_data_d     = m_data_q;
    m_last_d     = m_last_q;
    pkt0_inc     = 1'b0;
    pkt1_inc     = 1'b0;
    trunc_inc    = 1'b0;
    s0_ready     = 1'b0;
    s1_ready     = 1'b0;

    // Downstream took the held beat (or it was empty); refilled below if a beat is accepted.
    if (load) m_valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Tie goes to the input that was not granted last.
        if (req0 && (!req1 || last_grant_q)) begin
          state_d = GRANT0;
          wcnt_d  = '0;
        end else if (req1) begin
          state_d = GRANT1;
          wcnt_d  = '0;
        end
      end
      GRANT0, GRANT1: begin
        if (gnt1) s1_ready = load;
        else      s0_ready = load;
        if (sel_valid && load) begin
          m_valid_d = 1'b1;
          m_data_d  = sel_data;
          m_last_d  = sel_last | at_max;
          if (sel_last) begin
            state_d      = IDLE;
            last_grant_d = gnt1;
            pkt1_inc     = gnt1;
            pkt0_inc     = ~gnt1;
          end else if (at_max) begin
            state_d      = gnt1 ? FLUSH1 : FLUSH0;
            last_grant_d = gnt1;
            trunc_inc    = 1'b1;
          end else begin
            wcnt_d = wcnt_q + WC_W'(1);
          end
        end
      end
      FLUSH0: begin
        s0_ready = 1'b1;
        if (s00_axis.tvalid && s00_axis.tlast) state_d = IDLE;
      end
      FLUSH1: begin
        s1_ready = 1'b1;
        if (s01_axis.tvalid && s01_axis.tlast) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, output register, grant indication and saturating counters.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q        <= IDLE;
      last_grant_q   <= 1'b1;
      wcnt_q         <= '0;
      m_valid_q      <= 1'b0;
      m_data_q       <= '0;
      m_last_q       <= 1'b0;
      pkt0_q         <= '0;
      pkt1_q         <= '0;
      trunc_q        <= '0;
      active_grant_q <= 2'b00;
    end else begin
      state_q        <= state_d;
      last_grant_q   <= last_grant_d;
      wcnt_q         <= wcnt_d;
      m_valid_q      <= m_valid_d;
      m_data_q       <= m_data_d;
      m_last_q       <= m_last_d;
      active_grant_q <= {(state_d == GRANT1) || (state_d == FLUSH1),
                         (state_d == GRANT0) || (state_d == FLUSH0)};
      if (pkt0_inc && (pkt0_q != '1))   pkt0_q  <= pkt0_q + CNT_WIDTH'(1);
      if (pkt1_inc && (pkt1_q != '1))   pkt1_q  <= pkt1_q + CNT_WIDTH'(1);
      if (trunc_inc && (trunc_q != '1)) trunc_q <= trunc_q + CNT_WIDTH'(1);
    end
  end

  assign s00_axis.tready = s0_ready;
  assign s01_axis.tready = s1_ready;
  assign m00_axis.tvalid = m_valid_q;
  assign m00_axis.tdata  = m_data_q;
  assign m00_axis.tlast  = m_last_q;
  assign PKT_COUNT_00    = pkt0_q;
  assign PKT_COUNT_01    = pkt1_q;
  assign TRUNC_COUNT     = trunc_q;
  assign ACTIVE_GRANT    = active_grant_q;

endmodule

// File: tb/tb_cell_link_packet_arbiter.sv
// Scoreboard bench for cell_link_packet_arbiter. Data bit 31 tags the source input
// so the monitor can route each output beat to that input's expected-beat queue.
module tb_cell_link_packet_arbiter;
  localparam int DW   = 32;
  localparam int MAXW = 16;
  localparam int CW   = 16;

  logic ACLK = 1'b0;
  logic ARESETN;
  logic sup0, sup1;
  logic [CW-1:0] pkt0, pkt1, trunc;
  logic [1:0] agrant;

  always #5 ACLK = ~ACLK;

  cell_link_packet_arbiter_if #(.DATA_WIDTH(DW)) s00_if ();
  cell_link_packet_arbiter_if #(.DATA_WIDTH(DW)) s01_if ();
  cell_link_packet_arbiter_if #(.DATA_WIDTH(DW)) m00_if ();

  cell_link_packet_arbiter #(.DATA_WIDTH(DW), .MAX_PKT_WORDS(MAXW), .CNT_WIDTH(CW)) dut (
    .ACLK                 (ACLK),
    .ARESETN              (ARESETN),
    .s00_axis             (s00_if),
    .s01_axis             (s01_if),
    .m00_axis             (m00_if),
    .S00_ARB_REQ_SUPPRESS (sup0),
    .S01_ARB_REQ_SUPPRESS (sup1),
    .PKT_COUNT_00         (pkt0),
    .PKT_COUNT_01         (pkt1),
    .TRUNC_COUNT          (trunc),
    .ACTIVE_GRANT         (agrant)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  logic [32:0] exp_q0[$];
  logic [32:0] exp_q1[$];
  int exp_pkt0, exp_pkt1, exp_trunc;
  int order_q[$];
  int accepted0, accepted1;
  bit abort;
  bit rand_rdy;

  // monitor state
  logic        stall_p;
  logic [31:0] d_p;
  logic        l_p;
  bit          in_pkt;
  int          cur_src;

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  task automatic clear_model();
    exp_q0.delete();
    exp_q1.delete();
    exp_pkt0  = 0;
    exp_pkt1  = 0;
    exp_trunc = 0;
  endtask

  // Issue one packet of len beats on input src; expected output is recorded up front.
  task automatic send_pkt(input int src, input int len, input logic [31:0] base);
    int n_fwd;
    bit hs;
    int budget;
    logic [31:0] d;
    n_fwd = (len > MAXW) ? MAXW : len;
    for (int i = 0; i < n_fwd; i++) begin
      d = base + 32'(i);
      if (src == 0) exp_q0.push_back({(i == n_fwd - 1), d});
      else          exp_q1.push_back({(i == n_fwd - 1), d});
    end
    if (len > MAXW)    exp_trunc++;
    else if (src == 0) exp_pkt0++;
    else               exp_pkt1++;
    for (int i = 0; i < len; i++) begin
      d = base + 32'(i);
      if (src == 0) begin
        s00_if.tvalid = 1'b1; s00_if.tdata = d; s00_if.tlast = (i == len - 1);
      end else begin
        s01_if.tvalid = 1'b1; s01_if.tdata = d; s01_if.tlast = (i == len - 1);
      end
      hs = 1'b0;
      budget = 0;
      while (!hs && !abort) begin
        @(negedge ACLK);
        hs = (src == 0) ? s00_if.tready : s01_if.tready;
        @(posedge ACLK);
        #1;
        budget++;
        if (!hs && budget > 2000) begin
          fail_now("input_handshake_timeout");
          break;
        end
      end
      if (!hs) break;
      if (src == 0) accepted0++;
      else          accepted1++;
    end
    if (src == 0) s00_if.tvalid = 1'b0;
    else          s01_if.tvalid = 1'b0;
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      @(posedge ACLK);
      #1;
    end
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0) && budget < 1000) begin
      @(posedge ACLK);
      budget++;
    end
    if (exp_q0.size() != 0 || exp_q1.size() != 0) fail_now("drain_timeout");
    gap(3);
  endtask

  task automatic do_reset();
    ARESETN = 1'b0;
    clear_model();
    #20;
    @(negedge ACLK);
    ARESETN = 1'b1;
    @(posedge ACLK);
    #1;
  endtask

  task automatic check_counts();
    check("pkt_count_00", pkt0, exp_pkt0);
    check("pkt_count_01", pkt1, exp_pkt1);
    check("trunc_count", trunc, exp_trunc);
  endtask

  // downstream ready: constant 1 or random per cycle
  initial begin
    m00_if.tready = 1'b1;
    forever begin
      @(posedge ACLK);
      #1;
      m00_if.tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // output monitor: pops the expected beat for the tagged source on each handshake
  initial begin
    logic [32:0] e;
    int src;
    stall_p = 1'b0;
    in_pkt  = 1'b0;
    cur_src = 0;
    forever begin
      @(negedge ACLK);
      if (!ARESETN) begin
        stall_p = 1'b0;
        in_pkt  = 1'b0;
      end else begin
        if (stall_p)
          check("stall_hold", {m00_if.tvalid, m00_if.tlast, m00_if.tdata}, {1'b1, l_p, d_p});
        if (m00_if.tvalid && m00_if.tready) begin
          src = int'(m00_if.tdata[31]);
          if (in_pkt) check("no_interleave", src, cur_src);
          if ((src == 0 && exp_q0.size() == 0) || (src == 1 && exp_q1.size() == 0)) begin
            fail_now("unexpected_beat");
          end else begin
            e = (src == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            check("beat", {m00_if.tlast, m00_if.tdata}, e);
          end
          if (m00_if.tlast) begin
            in_pkt = 1'b0;
            order_q.push_back(src);
          end else begin
            in_pkt  = 1'b1;
            cur_src = src;
          end
        end
        stall_p = m00_if.tvalid && !m00_if.tready;
        d_p     = m00_if.tdata;
        l_p     = m00_if.tlast;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int budget;
    ARESETN = 1'b0;
    sup0 = 1'b0; sup1 = 1'b0;
    s00_if.tvalid = 1'b0; s00_if.tdata = '0; s00_if.tlast = 1'b0;
    s01_if.tvalid = 1'b0; s01_if.tdata = '0; s01_if.tlast = 1'b0;
    abort = 1'b0; rand_rdy = 1'b0;
    accepted0 = 0; accepted1 = 0;
    clear_model();
    repeat (3) @(posedge ACLK);
    #2;
    check("rst_tvalid", m00_if.tvalid, 0);
    check("rst_tdata", m00_if.tdata, 0);
    check("rst_tlast", m00_if.tlast, 0);
    check("rst_grant", agrant, 0);
    check("rst_s00_tready", s00_if.tready, 0);
    check_counts();
    @(negedge ACLK);
    ARESETN = 1'b1;
    @(posedge ACLK);
    #1;

    // 1: single 3-beat packet, two-cycle latency from first TVALID
    fork
      send_pkt(0, 3, 32'h0000_00A0);
      begin
        @(posedge ACLK); @(posedge ACLK); #2;
        check("t1_first_beat", {m00_if.tvalid, m00_if.tlast, m00_if.tdata}, {2'b10, 32'hA0});
        @(posedge ACLK); #2;
        check("t1_second_beat", {m00_if.tvalid, m00_if.tlast, m00_if.tdata}, {2'b10, 32'hA1});
        @(posedge ACLK); #2;
        check("t1_third_beat", {m00_if.tvalid, m00_if.tlast, m00_if.tdata}, {2'b11, 32'hA2});
      end
    join
    drain();
    check_counts();
    check("t1_idle_grant", agrant, 0);

    // 2: both inputs continuously busy, round-robin alternation
    do_reset();
    order_q.delete();
    fork
      for (int k = 0; k < 4; k++) send_pkt(0, 2, 32'h0001_0000 * (k + 1));
      for (int k = 0; k < 4; k++) send_pkt(1, 2, 32'h8000_0000 | (32'h0001_0000 * (k + 1)));
    join
    drain();
    check("t2_pkt_total", order_q.size(), 8);
    foreach (order_q[i]) check("t2_alternation", order_q[i], i % 2);
    check_counts();

    // 3: suppression of input 0, released during an input 1 packet
    order_q.delete();
    accepted1 = 0;
    sup0 = 1'b1;
    fork
      send_pkt(0, 3, 32'h0030_0000);
      begin
        send_pkt(1, 4, 32'h8031_0000);
        send_pkt(1, 4, 32'h8032_0000);
      end
      begin
        budget = 0;
        while (accepted1 < 2 && budget < 200) begin
          @(posedge ACLK); #3;
          budget++;
        end
        if (accepted1 < 2) fail_now("t3_wait_timeout");
        check("t3_grant_mid_pkt1", agrant, 2'b10);
        sup0 = 1'b0;
      end
    join
    drain();
    check("t3_pkt_total", order_q.size(), 3);
    if (order_q.size() == 3) begin
      check("t3_order0", order_q[0], 1);
      check("t3_order1", order_q[1], 0);
      check("t3_order2", order_q[2], 1);
    end
    check_counts();

    // 4: over-length packet truncated to MAXW beats, rest flushed
    order_q.delete();
    accepted1 = 0;
    send_pkt(1, 20, 32'h8040_0000);
    drain();
    check("t4_all_consumed", accepted1, 20);
    check_counts();
    send_pkt(1, MAXW, 32'h8041_0000);
    drain();
    check("t4_exact_max_not_trunc", order_q.size(), 2);
    check_counts();

    // 5: random downstream backpressure over 5-beat packets
    rand_rdy = 1'b1;
    fork
      send_pkt(0, 5, 32'h0050_0000);
      send_pkt(1, 5, 32'h8051_0000);
    join
    drain();
    check_counts();

    // randomized traffic on both inputs
    fork
      for (int k = 0; k < 12; k++) begin
        send_pkt(0, $urandom_range(1, 20), 32'h0060_0000 + 32'h0001_0000 * k);
        gap($urandom_range(0, 3));
      end
      for (int k = 0; k < 12; k++) begin
        send_pkt(1, $urandom_range(1, 20), 32'h8070_0000 + 32'h0001_0000 * k);
        gap($urandom_range(0, 3));
      end
    join
    drain();
    rand_rdy = 1'b0;
    gap(2);
    check_counts();

    // 6: asynchronous reset mid-packet
    accepted0 = 0;
    fork
      send_pkt(0, 4, 32'h0080_0000);
      begin
        budget = 0;
        while (accepted0 < 1 && budget < 200) begin
          @(posedge ACLK); #3;
          budget++;
        end
        if (accepted0 < 1) fail_now("t6_wait_timeout");
        abort = 1'b1;
        ARESETN = 1'b0;
        #1;
        check("t6_async_tvalid", m00_if.tvalid, 0);
        check("t6_async_grant", agrant, 0);
        check("t6_async_pkt_count", pkt0, 0);
      end
    join
    clear_model();
    gap(3);
    abort = 1'b0;
    @(negedge ACLK);
    ARESETN = 1'b1;
    @(posedge ACLK);
    #1;
    order_q.delete();
    fork
      send_pkt(0, 3, 32'h0090_0000);
      send_pkt(1, 2, 32'h8091_0000);
    join
    drain();
    check("t6_pkt_total", order_q.size(), 2);
    if (order_q.size() == 2) check("t6_first_grant", order_q[0], 0);
    check_counts();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/cell_link_packet_arbiter.md
Name: cell_link_packet_arbiter

Overview:
Packet-granular round-robin arbiter that shares the single outbound cell-link AXI-Stream between two backpressured input streams (S00, S01).
- Grants one input at a time and holds the grant until that input's TLAST.
- Honours per-input arbitration-request suppression.
- Truncates and flushes over-length packets so a stuck source cannot hold the link.
- Sits between the per-link receive FIFOs and the outbound cell-link serializer; exports per-port packet and truncation counters for the status register block.

Parameters:
DATA_WIDTH, 32, TDATA width
MAX_PKT_WORDS, 16, max beats per packet before forced truncation (>=2)
CNT_WIDTH, 16, width of saturating statistics counters

Ports:
ACLK  in  1  single clock for all logic
ARESETN  in  1  asynchronous active-low reset
S00_AXIS_TVALID  in  1  input 0 beat valid
S00_AXIS_TREADY  out  1  input 0 beat accepted
S00_AXIS_TDATA  in  DATA_WIDTH  input 0 data
S00_AXIS_TLAST  in  1  input 0 end of packet
S01_AXIS_TVALID  in  1  input 1 beat valid
S01_AXIS_TREADY  out  1  input 1 beat accepted
S01_AXIS_TDATA  in  DATA_WIDTH  input 1 data
S01_AXIS_TLAST  in  1  input 1 end of packet
M00_AXIS_TVALID  out  1  output beat valid (registered)
M00_AXIS_TREADY  in  1  downstream ready
M00_AXIS_TDATA  out  DATA_WIDTH  output data (registered)
M00_AXIS_TLAST  out  1  output end of packet (registered)
S00_ARB_REQ_SUPPRESS  in  1  1 = input 0 not considered for new grants
S01_ARB_REQ_SUPPRESS  in  1  1 = input 1 not considered for new grants
PKT_COUNT_00  out  CNT_WIDTH  packets completed from input 0, saturating
PKT_COUNT_01  out  CNT_WIDTH  packets completed from input 1, saturating
TRUNC_COUNT  out  CNT_WIDTH  truncation events (both inputs), saturating
ACTIVE_GRANT  out  2  bit0/bit1 = input 0/1 currently granted (GRANT or FLUSH)

Behaviour:
- Reset (async, ARESETN low):
  - State goes to IDLE; last_grant=1, so input 0 wins the first tie.
  - All outputs are 0, including M00_AXIS_TVALID, M00_AXIS_TDATA, M00_AXIS_TLAST, all counters and ACTIVE_GRANT.
  - Reset mid-packet drops the packet in flight. No recovery of partial packets.
- Request qualification: reqN = SNN_AXIS_TVALID & ~SNN_ARB_REQ_SUPPRESS. Suppression is evaluated in IDLE only; asserting it mid-packet does not affect the current grant.
- States: IDLE, GRANT0, GRANT1, FLUSH0, FLUSH1.
- IDLE:
  - Both TREADY are 0.
  - If only one request is present, go to that input's GRANTn.
  - If both are present, grant the input != last_grant.
  - If none, stay in IDLE.
  - Arbitration costs one cycle: there is no transfer in the IDLE cycle.
- Output register:
  - load = ~M00_AXIS_TVALID | M00_AXIS_TREADY.
  - In GRANTn, SNN_AXIS_TREADY = load; the non-granted TREADY is 0.
  - An accepted input beat appears on M00 on the next cycle. Latency is 1 cycle.
  - M00_AXIS_TVALID clears when the downstream accepts and no new beat loads. Data and TLAST hold while TVALID=1 and TREADY=0.
- Word counter:
  - Clears on entry to GRANTn and increments per accepted beat.
  - Accepted beat with TLAST=1: M00 TLAST=1; PKT_COUNT_nn increments; last_grant=n; next state IDLE.
  - Accepted beat #MAX_PKT_WORDS (count==MAX_PKT_WORDS-1) with TLAST=0: forward it with M00 TLAST forced to 1; TRUNC_COUNT increments; PKT_COUNT does not; last_grant=n; next state FLUSHn.
  - If beat #MAX_PKT_WORDS has TLAST=1, it is a normal end of packet, not a truncation.
- FLUSHn:
  - SNN_AXIS_TREADY=1 unconditionally; beats are discarded and do not reach M00.
  - On an accepted beat with TLAST=1, go to IDLE.
  - The other input's TREADY is 0.
- Granted input drops TVALID mid-packet: stay in GRANTn indefinitely. Recovery is upstream's responsibility.
- Counters saturate at all-ones and never wrap.
- ACTIVE_GRANT is registered from the state: 01 in GRANT0/FLUSH0, 10 in GRANT1/FLUSH1, 00 in IDLE.
- Back-to-back packets from one input, with the other idle or suppressed: one IDLE bubble cycle between packets.
- Protocol invariants:
  - M00 never interleaves beats of two packets.
  - M00 TVALID never drops without a handshake.

Test Plan:
1. Reset, then input 0 sends a 3-beat packet (0xA0..0xA2, TLAST on the third), M00_TREADY=1 -> M00 shows A0, A1, A2 on consecutive cycles, starting 2 cycles after the first TVALID; TLAST on A2; PKT_COUNT_00=1.
2. Both inputs continuously present 2-beat packets, M00_TREADY=1 -> output alternates packets 0,1,0,1 with no interleaving; after 8 packets PKT_COUNT_00=4 and PKT_COUNT_01=4.
3. S00_ARB_REQ_SUPPRESS=1 and both inputs valid -> only input 1 is granted. Deassert suppress during an input 1 packet -> that packet completes, then input 0 is granted.
4. MAX_PKT_WORDS=16; input 1 sends 20 beats with TLAST on beat 20 -> M00 carries exactly 16 beats with TLAST on beat 16; beats 17-20 are consumed (TREADY=1) but not forwarded; TRUNC_COUNT=1; PKT_COUNT_01=0.
5. M00_TREADY toggles randomly during a 5-beat packet -> no beat is lost or duplicated; TDATA is stable while TVALID=1 and TREADY=0.
6. ARESETN pulsed low mid-packet (beat 2 of 4) -> M00_TVALID=0 and ACTIVE_GRANT=00 immediately, without waiting for a clock edge. After release, a new packet from input 0 is granted first and forwards correctly.
